// File: rtl/control_unit.sv
// Instruction decoder for the image-filter processor: decodes OpCode/F into a
// control word and registers it so the execute stage sees it one cycle later.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] OpCode,
    input  logic [3:0] F,
    output logic       SEL_A,
    output logic       SEL_B,
    output logic       SEL_EXT,
    output logic [1:0] SELOP_B,
    output logic [1:0] SELOP_A,
    output logic       SEL_RES,
    output logic [2:0] ALU_CTRL,
    output logic       WE_MEM,
    output logic       SEL_DAT,
    output logic       SEL_C,
    output logic       WE_C_AUX,
    output logic       WE_V,
    output logic       COMPARA,
    output logic       SUMA_RESTA,
    output logic       SALTO,
    output logic       PROHIB
);

    typedef enum logic [3:0] {
        OP_SUM  = 4'b0000,
        OP_SUMI = 4'b0001,
        OP_RES  = 4'b0010,
        OP_RESI = 4'b0011,
        OP_MUL  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_MOV  = 4'b0111,
        OP_COMP = 4'b1000,
        OP_STO  = 4'b1001,
        OP_VECH = 4'b1010,
        OP_OBT  = 4'b1011,
        OP_CAR  = 4'b1100,
        OP_ILL  = 4'b1101,
        OP_CARI = 4'b1110,
        OP_ALMB = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_MUL    = 3'b010,
        ALU_AND    = 3'b011,
        ALU_OR     = 3'b100,
        ALU_PASS_B = 3'b101
    } alu_e;

    typedef struct packed {
        logic       sel_a;
        logic       sel_b;
        logic       sel_ext;
        logic [1:0] selop_b;
        logic [1:0] selop_a;
        logic       sel_res;
        alu_e       alu_ctrl;
        logic       we_mem;
        logic       sel_dat;
        logic       sel_c;
        logic       we_c_aux;
        logic       we_v;
        logic       compara;
        logic       suma_resta;
        logic       salto;
        logic       prohib;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ctrl_q;

    // Decoding F[1:0] through a case means an unknown format field lands in the
    // default arm, so X/Z on any input yields the all-zero NOP word.
    always_comb begin
        // NOTE: assign the full default first so every path drives every field; no latch.
        dec = '0;
        case (F[1:0])
            2'b00, 2'b01, 2'b10: begin
                case (opcode_e'(OpCode))
                    OP_SUM: begin
                        dec.alu_ctrl = ALU_ADD;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_SUMI: begin
                        dec.sel_b    = 1'b1;
                        dec.sel_ext  = 1'b1;
                        dec.alu_ctrl = ALU_ADD;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_RES: begin
                        dec.alu_ctrl   = ALU_SUB;
                        dec.suma_resta = 1'b1;
                        dec.we_c_aux   = 1'b1;
                    end
                    OP_RESI: begin
                        dec.sel_b      = 1'b1;
                        dec.sel_ext    = 1'b1;
                        dec.alu_ctrl   = ALU_SUB;
                        dec.suma_resta = 1'b1;
                        dec.we_c_aux   = 1'b1;
                    end
                    OP_MUL: begin
                        dec.alu_ctrl = ALU_MUL;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_AND: begin
                        dec.alu_ctrl = ALU_AND;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_OR: begin
                        dec.alu_ctrl = ALU_OR;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_MOV: begin
                        dec.sel_b    = 1'b1;
                        dec.alu_ctrl = ALU_PASS_B;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_COMP: begin
                        dec.alu_ctrl   = ALU_SUB;
                        dec.suma_resta = 1'b1;
                        dec.compara    = 1'b1;
                        dec.salto      = 1'b1;
                    end
                    OP_STO: begin
                        // Address is base register plus sign-extended offset.
                        dec.sel_b    = 1'b1;
                        dec.sel_ext  = 1'b1;
                        dec.alu_ctrl = ALU_ADD;
                        dec.we_mem   = 1'b1;
                    end
                    OP_VECH: begin
                        dec.sel_a    = 1'b1;
                        dec.selop_a  = 2'b01;
                        dec.selop_b  = 2'b01;
                        dec.alu_ctrl = ALU_ADD;
                        dec.we_v     = 1'b1;
                    end
                    OP_OBT: begin
                        dec.sel_a    = 1'b1;
                        dec.selop_a  = 2'b10;
                        dec.sel_res  = 1'b1;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_CAR: begin
                        dec.alu_ctrl = ALU_ADD;
                        dec.sel_res  = 1'b1;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_ILL: begin
                        dec.prohib = 1'b1;
                    end
                    OP_CARI: begin
                        dec.sel_b    = 1'b1;
                        dec.sel_ext  = 1'b1;
                        dec.alu_ctrl = ALU_ADD;
                        dec.sel_res  = 1'b1;
                        dec.we_c_aux = 1'b1;
                    end
                    OP_ALMB: begin
                        dec.selop_b  = 2'b10;
                        dec.alu_ctrl = ALU_ADD;
                        dec.we_mem   = 1'b1;
                        dec.sel_dat  = 1'b1;
                    end
                    default: dec = '0;
                endcase
            end
            default: dec = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= dec;
    end

    assign SEL_A      = ctrl_q.sel_a;
    assign SEL_B      = ctrl_q.sel_b;
    assign SEL_EXT    = ctrl_q.sel_ext;
    assign SELOP_B    = ctrl_q.selop_b;
    assign SELOP_A    = ctrl_q.selop_a;
    assign SEL_RES    = ctrl_q.sel_res;
    assign ALU_CTRL   = ctrl_q.alu_ctrl;
    assign WE_MEM     = ctrl_q.we_mem;
    assign SEL_DAT    = ctrl_q.sel_dat;
    assign SEL_C      = ctrl_q.sel_c;
    assign WE_C_AUX   = ctrl_q.we_c_aux;
    assign WE_V       = ctrl_q.we_v;
    assign COMPARA    = ctrl_q.compara;
    assign SUMA_RESTA = ctrl_q.suma_resta;
    assign SALTO      = ctrl_q.salto;
    assign PROHIB     = ctrl_q.prohib;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed reset/latency/sweep/NOP cases
// plus a random run compared against a rule-based reference model.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] OpCode;
    logic [3:0] F;
    logic       SEL_A, SEL_B, SEL_EXT, SEL_RES, WE_MEM, SEL_DAT, SEL_C;
    logic       WE_C_AUX, WE_V, COMPARA, SUMA_RESTA, SALTO, PROHIB;
    logic [1:0] SELOP_B, SELOP_A;
    logic [2:0] ALU_CTRL;

    int n_checks = 0;
    int n_pass   = 0;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .OpCode     (OpCode),
        .F          (F),
        .SEL_A      (SEL_A),
        .SEL_B      (SEL_B),
        .SEL_EXT    (SEL_EXT),
        .SELOP_B    (SELOP_B),
        .SELOP_A    (SELOP_A),
        .SEL_RES    (SEL_RES),
        .ALU_CTRL   (ALU_CTRL),
        .WE_MEM     (WE_MEM),
        .SEL_DAT    (SEL_DAT),
        .SEL_C      (SEL_C),
        .WE_C_AUX   (WE_C_AUX),
        .WE_V       (WE_V),
        .COMPARA    (COMPARA),
        .SUMA_RESTA (SUMA_RESTA),
        .SALTO      (SALTO),
        .PROHIB     (PROHIB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All outputs packed in port order for whole-word comparison.
    function automatic logic [19:0] observed();
        return {SEL_A, SEL_B, SEL_EXT, SELOP_B, SELOP_A, SEL_RES, ALU_CTRL,
                WE_MEM, SEL_DAT, SEL_C, WE_C_AUX, WE_V, COMPARA, SUMA_RESTA,
                SALTO, PROHIB};
    endfunction

    // Reference model: each field derived from the set of opcodes that assert it.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [3:0] fmt);
        int o;
        logic [2:0] alu_tab [16];
        logic       sa, sb, se, sr, wm, sd, wc, wv, cp, sub, sj, pr;
        logic [1:0] ob, oa;
        if (fmt[1:0] == 2'b11) return '0;
        o = int'(op);
        alu_tab = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                    3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        sa  = (o == 10 || o == 11);
        sb  = (o inside {1, 3, 7, 9, 14});
        se  = (o inside {1, 3, 9, 14});
        ob  = (o == 10) ? 2'b01 : (o == 15) ? 2'b10 : 2'b00;
        oa  = (o == 10) ? 2'b01 : (o == 11) ? 2'b10 : 2'b00;
        sr  = (o inside {11, 12, 14});
        wm  = (o == 9 || o == 15);
        sd  = (o == 15);
        wc  = (o <= 7) || (o inside {11, 12, 14});
        wv  = (o == 10);
        cp  = (o == 8);
        sub = (o inside {2, 3, 8});
        sj  = (o == 8);
        pr  = (o == 13);
        return {sa, sb, se, ob, oa, sr, alu_tab[o], wm, sd, 1'b0, wc, wv, cp, sub, sj, pr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    logic [19:0] exp_word;

    initial begin
        rst    = 1'b1;
        OpCode = 4'b0000;
        F      = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_hold", 32'(observed()), 32'h0);

        // First capture after release.
        rst = 1'b0;
        @(negedge clk);
        check("first_capture", 32'(observed()), 32'(model(4'b0000, 4'b0000)));
        check("first_we_c_aux", 32'(WE_C_AUX), 32'h1);

        // Mid-cycle asynchronous reset.
        #2 rst = 1'b1;
        #1 check("async_reset", 32'(observed()), 32'h0);
        @(negedge clk);
        check("reset_held", 32'(observed()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_sum", 32'(observed()), 32'(model(4'b0000, 4'b0000)));

        // Latency: inputs change just after the capturing edge.
        OpCode = 4'b0001; F = 4'b0001;
        @(posedge clk);
        #1 OpCode = 4'b0100; F = 4'b0000;
        #1 check("lat_early", 32'(observed()), 32'(model(4'b0001, 4'b0001)));
        check("lat_sumi_bits", 32'({SEL_B, SEL_EXT, WE_C_AUX}), 32'h7);
        @(negedge clk);
        check("lat_hold", 32'(observed()), 32'(model(4'b0001, 4'b0001)));
        @(negedge clk);
        check("lat_next", 32'(observed()), 32'(model(4'b0100, 4'b0000)));

        // Sweep every opcode with its natural format field.
        for (int op = 0; op < 16; op++) begin
            OpCode = 4'(op);
            F = (op inside {1, 3, 7, 14}) ? 4'b0001 : (op == 9) ? 4'b0010 : 4'b0000;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check($sformatf("sweep_op%0d", op), 32'(observed()), 32'(model(OpCode, F)));
            end
        end

        // Illegal opcode.
        OpCode = 4'b1101; F = 4'b0000;
        @(negedge clk);
        check("illegal_prohib", 32'(PROHIB), 32'h1);
        check("illegal_we", 32'({WE_MEM, WE_C_AUX, WE_V}), 32'h0);

        // NOP priority over the opcode decode.
        OpCode = 4'b0000; F = 4'b0011;
        @(negedge clk);
        check("nop_sum", 32'(observed()), 32'h0);
        OpCode = 4'b1001; F = 4'b1111;
        @(negedge clk);
        check("nop_sto", 32'(observed()), 32'h0);
        check("nop_sto_we_mem", 32'(WE_MEM), 32'h0);

        // Random run with per-cycle invariant checks.
        OpCode = 4'($urandom_range(15));
        F      = 4'($urandom_range(15));
        exp_word = model(OpCode, F);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check("rand_word", 32'(observed()), 32'(exp_word));
            check("rand_we_onehot", 32'($countones({WE_MEM, WE_C_AUX, WE_V}) <= 1), 32'h1);
            check("rand_prohib_we", 32'(PROHIB && (WE_MEM || WE_C_AUX || WE_V)), 32'h0);
            OpCode = 4'($urandom_range(15));
            F      = 4'($urandom_range(15));
            exp_word = model(OpCode, F);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction decoder and control-word register for the image-filter processor datapath.
- Decodes a 4-bit OpCode and a 4-bit format field F into datapath select, ALU and write-enable controls.
- Registers the decoded control word on the clock edge, so the execute stage sees stable controls one cycle after decode.

Parameters:
- None. All widths are fixed.

Ports:
- clk  in  1  system clock; rising-edge active.
- rst  in  1  reset; asynchronous, active-high.
- OpCode  in  4  instruction opcode.
- F  in  4  format field; only F[1:0] is decoded, F[3:2] is ignored.
- SEL_A  out  1  operand-A source: 0 = scalar register, 1 = vector register.
- SEL_B  out  1  operand-B source: 0 = register, 1 = extended immediate.
- SEL_EXT  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- SELOP_B  out  2  operand-B sub-select: 00 scalar, 01 vector lane, 10 byte lane.
- SELOP_A  out  2  operand-A sub-select: 00 scalar, 01 vector lane, 10 element extract.
- SEL_RES  out  1  writeback source: 0 = ALU result, 1 = memory data.
- ALU_CTRL  out  3  ALU operation: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 PASS_B; 110 and 111 are unused.
- WE_MEM  out  1  data-memory write enable.
- SEL_DAT  out  1  store-data source: 0 = scalar register, 1 = vector byte.
- SEL_C  out  1  destination select: 0 = Rd field, 1 = alternate field. Always 0 for the current ISA.
- WE_C_AUX  out  1  scalar register-file write enable.
- WE_V  out  1  vector register-file write enable.
- COMPARA  out  1  compare operation, which updates flags.
- SUMA_RESTA  out  1  adder mode: 0 = add, 1 = subtract.
- SALTO  out  1  conditional branch enable.
- PROHIB  out  1  illegal-opcode flag.

Behaviour:
- The combinational decode of (OpCode, F) is captured into output registers on each rising clk edge.
- Latency is exactly 1 cycle. There is no handshake; a new instruction can be decoded every cycle.
- rst=1 asynchronously forces every output to 0, which is the NOP control word. Outputs stay 0 while rst is held.
- The first capture after rst deasserts occurs on the next rising clk edge.
- Every output is 0 unless listed for the decoded instruction below.
- NOP: F[1:0]=11 with any OpCode gives all outputs 0. This check has priority over the opcode decode.
- SUM 0000: ALU_CTRL=000, WE_C_AUX=1.
- SUMI 0001: SEL_B=1, SEL_EXT=1, ALU_CTRL=000, WE_C_AUX=1.
- RES 0010: ALU_CTRL=001, SUMA_RESTA=1, WE_C_AUX=1.
- RESI 0011: SEL_B=1, SEL_EXT=1, ALU_CTRL=001, SUMA_RESTA=1, WE_C_AUX=1.
- MUL 0100: ALU_CTRL=010, WE_C_AUX=1.
- AND 0101: ALU_CTRL=011, WE_C_AUX=1.
- OR 0110: ALU_CTRL=100, WE_C_AUX=1.
- MOV 0111: SEL_B=1, ALU_CTRL=101, WE_C_AUX=1.
- COMP 1000: ALU_CTRL=001, SUMA_RESTA=1, COMPARA=1, SALTO=1. There is no register or memory write.
- STO 1001: SEL_B=1, SEL_EXT=1, ALU_CTRL=000 (address = A + imm), WE_MEM=1, SEL_DAT=0.
- VECH 1010: SEL_A=1, SELOP_A=01, SELOP_B=01, ALU_CTRL=000, WE_V=1.
- OBT 1011: SEL_A=1, SELOP_A=10, SEL_RES=1, WE_C_AUX=1.
- CAR 1100: ALU_CTRL=000, SEL_RES=1, WE_C_AUX=1.
- 1101 (undefined): PROHIB=1. All write enables are 0, so no architectural state changes.
- CARI 1110: SEL_B=1, SEL_EXT=1, ALU_CTRL=000, SEL_RES=1, WE_C_AUX=1.
- ALMB 1111: SELOP_B=10, ALU_CTRL=000, WE_MEM=1, SEL_DAT=1.
- Values of F other than 11 do not alter the decode.
- Invariants:
  - At most one of WE_MEM, WE_C_AUX and WE_V is 1 in any cycle.
  - PROHIB=1 implies every write enable is 0.
- X or Z on the inputs must not be captured as a write enable. The decode uses a default branch that yields the all-zero word.

Test Plan:
- Reset: assert rst mid-cycle while OpCode=0000, F=00 is loaded -> all outputs are 0 immediately, without waiting for a clk edge. Release rst, then clk -> WE_C_AUX=1, ALU_CTRL=000.
- Latency: apply SUMI (0001, F=01) and change the inputs just after the edge -> outputs show SEL_B=1, SEL_EXT=1, WE_C_AUX=1 exactly one cycle later and hold that value until the next edge.
- Sweep: apply all 16 opcodes with F=00 (F=01 for SUMI, RESI, MOV, CARI; F=10 for STO), holding each for several cycles -> every output matches the Behaviour list for that opcode.
- Illegal: OpCode=1101, F=00 -> PROHIB=1, WE_MEM=0, WE_C_AUX=0, WE_V=0.
- NOP priority: OpCode=0000, F=0011, then OpCode=1001, F=1111 -> all outputs 0 in both cases, including WE_MEM=0 for the STO opcode.
- Invariant check: every cycle of a random OpCode/F run -> write enables are one-hot or zero, and PROHIB=1 never coincides with any write enable.
